// File: rtl/enc_gray_seq.sv
// rtl/enc_gray_seq.sv - Gray-code sequence generator with ready/valid output handshake.
// Optional parity output enabled by macro ENC_GRAY_SEQ_PARITY_EN.
module enc_gray_seq #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] limit,
  input  logic             wrap_en,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin_idx,
  output logic             busy,
`ifdef ENC_GRAY_SEQ_PARITY_EN
  output logic             done,
  output logic             parity
`else
  output logic             done
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             wrap_q, wrap_d;
  logic             stop_pend_q, stop_pend_d;

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    limit_d     = limit_q;
    wrap_d      = wrap_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          limit_d     = limit;
          wrap_d      = wrap_en;
          bin_d       = '0;
          stop_pend_d = 1'b0;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        // Compare before incrementing so an all-ones limit never overflows bin_idx.
        if (out_ready) begin
          if (stop_pend_q || stop) begin
            state_d     = S_DONE;
            stop_pend_d = 1'b0;
          end else if (bin_q == limit_q) begin
            if (wrap_q) begin
              bin_d = '0;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            bin_d = bin_q + WIDTH'(1);
          end
        end else if (stop) begin
          stop_pend_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bin_q       <= '0;
      gray_q      <= '0;
      limit_q     <= '0;
      wrap_q      <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      gray_q      <= gray_d;
      limit_q     <= limit_d;
      wrap_q      <= wrap_d;
      stop_pend_q <= stop_pend_d;
    end
  end

`ifdef ENC_GRAY_SEQ_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^gray_d;
    end
  end

  assign parity = parity_q;
`endif

  assign out_valid = (state_q == S_RUN);
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign gray      = gray_q;
  assign bin_idx   = bin_q;

endmodule

// File: tb/tb_enc_gray_seq.sv
// tb/tb_enc_gray_seq.sv - Scoreboard testbench for enc_gray_seq (WIDTH=10).
module tb_enc_gray_seq;

  localparam int WIDTH = 10;

  logic             clk;
  logic             rst;
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] limit;
  logic             wrap_en;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] gray;
  logic [WIDTH-1:0] bin_idx;
  logic             busy;
  logic             done;
`ifdef ENC_GRAY_SEQ_PARITY_EN
  logic             parity;
`endif

  enc_gray_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .limit     (limit),
    .wrap_en   (wrap_en),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .gray      (gray),
    .bin_idx   (bin_idx),
    .busy      (busy),
`ifdef ENC_GRAY_SEQ_PARITY_EN
    .done      (done),
    .parity    (parity)
`else
    .done      (done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit               is_done;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] b);
    exp_t e;
    e.is_done = 1'b0;
    e.g = g;
    e.b = b;
    exp_q.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1;
    e.g = '0;
    e.b = '0;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) tick(1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending expected 0 pending", name, exp_q.size());
      exp_q.delete();
    end
    tick(2);
  endtask

  task automatic do_start(input logic [WIDTH-1:0] lim, input logic wrap, input logic with_stop);
    limit   = lim;
    wrap_en = wrap;
    start   = 1'b1;
    stop    = with_stop;
    tick(1);
    start   = 1'b0;
    stop    = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every transfer and every done pulse.
  logic [WIDTH-1:0] stall_g, stall_b, prev_g;
  bit               stall_prev = 0;
  bit               have_prev = 0;
`ifdef ENC_GRAY_SEQ_PARITY_EN
  logic             prev_par;
`endif

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_prev = 0;
      have_prev  = 0;
    end else begin
      if (stall_prev) begin
        chk("hold_gray", 32'(gray), 32'(stall_g));
        chk("hold_bin", 32'(bin_idx), 32'(stall_b));
      end
      stall_prev = out_valid && !out_ready;
      stall_g    = gray;
      stall_b    = bin_idx;
      if (out_valid && out_ready) begin
        chk("busy_in_run", 32'(busy), 32'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(bin_idx), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("word_kind", 32'(0), 32'(e.is_done));
          chk("gray", 32'(gray), 32'(e.g));
          chk("bin_idx", 32'(bin_idx), 32'(e.b));
        end
        if (have_prev && bin_idx != '0) begin
          chk("one_bit_step", 32'($countones(gray ^ prev_g)), 32'd1);
`ifdef ENC_GRAY_SEQ_PARITY_EN
          chk("parity_toggle", 32'(parity), 32'(~prev_par));
`endif
        end
`ifdef ENC_GRAY_SEQ_PARITY_EN
        chk("parity_value", 32'(parity), 32'(^gray));
        prev_par = parity;
`endif
        prev_g    = gray;
        have_prev = 1;
      end
      if (done) begin
        chk("done_valid_low", 32'(out_valid), 32'd0);
        chk("done_busy_low", 32'(busy), 32'd0);
        have_prev = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("done_kind", 32'd1, 32'(e.is_done));
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    limit     = '0;
    wrap_en   = 1'b0;
    out_ready = 1'b1;
    tick(2);
    // Reset holds even with start asserted.
    start = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_gray", 32'(gray), 32'd0);
    chk("rst_bin", 32'(bin_idx), 32'd0);
`ifdef ENC_GRAY_SEQ_PARITY_EN
    chk("rst_parity", 32'(parity), 32'd0);
`endif
    tick(1);
    start = 1'b0;
    rst   = 1'b0;
    tick(1);

    // Basic limit=5 run.
    push_word(10'h000, 10'd0); push_word(10'h001, 10'd1); push_word(10'h003, 10'd2);
    push_word(10'h002, 10'd3); push_word(10'h006, 10'd4); push_word(10'h007, 10'd5);
    push_done();
    do_start(10'd5, 1'b0, 1'b0);
    @(negedge clk);
    chk("latency1_valid", 32'(out_valid), 32'd1);
    chk("latency1_gray", 32'(gray), 32'd0);
    @(posedge clk); #1;
    drain("basic");

    // Backpressure at bin_idx=2.
    push_word(10'h000, 10'd0); push_word(10'h001, 10'd1); push_word(10'h003, 10'd2);
    push_word(10'h002, 10'd3); push_done();
    do_start(10'd3, 1'b0, 1'b0);
    tick(2);
    out_ready = 1'b0;
    @(negedge clk);
    chk("stall_gray", 32'(gray), 32'h3);
    chk("stall_bin", 32'(bin_idx), 32'd2);
    tick(3);
    out_ready = 1'b1;
    drain("backpressure");

    // Wrap mode with limit=2; inputs changed mid-run must not matter.
    push_word(10'h000, 10'd0); push_word(10'h001, 10'd1); push_word(10'h003, 10'd2);
    push_word(10'h000, 10'd0); push_word(10'h001, 10'd1); push_word(10'h003, 10'd2);
    push_word(10'h000, 10'd0); push_word(10'h001, 10'd1); push_word(10'h003, 10'd2);
    push_done();
    do_start(10'd2, 1'b1, 1'b0);
    limit   = 10'd0;
    wrap_en = 1'b0;
    tick(8);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    drain("wrap_stop");

    // Stop at bin_idx=4 under backpressure; start during run ignored.
    push_word(10'h000, 10'd0); push_word(10'h001, 10'd1); push_word(10'h003, 10'd2);
    push_word(10'h002, 10'd3); push_word(10'h006, 10'd4); push_done();
    do_start(10'd9, 1'b0, 1'b0);
    tick(2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    out_ready = 1'b0;
    stop      = 1'b1;
    tick(1);
    stop = 1'b0;
    tick(1);
    out_ready = 1'b1;
    drain("stop_pending");

    // Reset at bin_idx=7 mid-run, then start+stop together with limit=0.
    for (int i = 0; i < 7; i++) push_word(WIDTH'(i ^ (i >> 1)), WIDTH'(i));
    do_start(10'd9, 1'b0, 1'b0);
    tick(7);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_bin", 32'(bin_idx), 32'd0);
    chk("abort_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    push_word(10'h000, 10'd0); push_done();
    do_start(10'd0, 1'b0, 1'b1);
    drain("limit0");

    // Full range: 1024 words, last gray 0x200.
    for (int i = 0; i < 1024; i++) push_word(WIDTH'(i ^ (i >> 1)), WIDTH'(i));
    push_done();
    chk("last_gray_model", 32'(exp_q[1023].g), 32'h200);
    do_start(10'h3FF, 1'b0, 1'b0);
    drain("full_range");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/enc_gray_seq.md
ENC_GRAY_SEQ -- requirements
Module: enc_gray_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 10, code width in bits (legal range 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  single-cycle request to begin a sequence.
REQ-005 SHALL have port stop  input  1  request to end the running sequence early.
REQ-006 SHALL have port limit  input  WIDTH  last binary index of the sequence, sampled on accepted start.
REQ-007 SHALL have port wrap_en  input  1  continuous mode, sampled on accepted start.
REQ-008 SHALL have port out_ready  input  1  downstream accepts the current word.
REQ-009 SHALL have port out_valid  output  1  gray/bin_idx hold a valid word.
REQ-010 SHALL have port gray  output  WIDTH  Gray code of bin_idx.
REQ-011 SHALL have port bin_idx  output  WIDTH  binary index of the current word.
REQ-012 SHALL have port busy  output  1  high in RUN.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a sequence ends.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE: start=1 SHALL capture limit and wrap_en, set bin_idx=0, and enter RUN; out_valid=1 with gray=0 on the next cycle (latency 1).
REQ-016 gray SHALL equal bin_idx XOR (bin_idx >> 1), registered, always aligned with bin_idx in the same cycle.
REQ-017 Transfer SHALL occur on a cycle with out_valid=1 and out_ready=1; while out_valid=1 and out_ready=0, gray and bin_idx SHALL hold stable.
REQ-018 On transfer with bin_idx < captured limit, bin_idx SHALL increment by 1 and out_valid SHALL stay high (back-to-back, one word per cycle).
REQ-019 On transfer with bin_idx == captured limit: wrap_en=1 SHALL set bin_idx=0 and remain in RUN; wrap_en=0 SHALL enter DONE.
REQ-020 In RUN, stop=1 SHALL set a pending-stop flag; the next transfer (including one in the same cycle as stop) SHALL enter DONE instead of advancing; the word under handshake is never withdrawn.
REQ-021 DONE SHALL last exactly one cycle with done=1, out_valid=0, busy=0, then return to IDLE.
REQ-022 start SHALL be ignored in RUN and DONE; stop SHALL be ignored in IDLE and DONE; start and stop together in IDLE SHALL start (stop ignored).
REQ-023 limit=0 SHALL produce one word (gray=0) then DONE; limit=all-ones SHALL produce 2^WIDTH words with no overflow of bin_idx.
REQ-024 Changes to limit or wrap_en during RUN SHALL have no effect on the running sequence.

Reset
REQ-025 rst=1 SHALL force IDLE, out_valid=0, busy=0, done=0, gray=0, bin_idx=0, and clear pending-stop, overriding all other inputs in that cycle.
REQ-026 rst asserted mid-sequence SHALL abort without a done pulse; the first post-reset start SHALL begin again at bin_idx=0.

Configuration
REQ-027 Macro ENC_GRAY_SEQ_PARITY_EN defined SHALL add output port parity (1 bit) equal to XOR of all gray bits, registered and aligned with gray, 0 in reset.
REQ-028 Macro ENC_GRAY_SEQ_PARITY_EN undefined SHALL omit the parity port; all other behaviour is identical.

Verification
REQ-029 WIDTH=10, limit=5, wrap_en=0, out_ready=1, pulse start -> gray 0,1,3,2,6,7 on consecutive cycles, then done=1 for one cycle, out_valid=0.
REQ-030 limit=3, out_ready low for 3 cycles while bin_idx=2 -> gray=3, bin_idx=2 held stable, sequence resumes with gray=2 at bin_idx=3.
REQ-031 limit=2, wrap_en=1, out_ready=1 for 8 cycles -> gray 0,1,3,0,1,3,0,1, no done; then stop -> done after next transfer.
REQ-032 stop asserted with bin_idx=4, out_ready=0 for 2 cycles then 1 -> word gray=6 delivered once, then DONE, no gray=7.
REQ-033 rst at bin_idx=7 mid-run -> next cycle out_valid=0, busy=0, no done; new start yields gray=0.
REQ-034 limit=1023, out_ready=1 -> 1024 words, last gray=0x200, each consecutive pair differs in exactly one bit; with ENC_GRAY_SEQ_PARITY_EN, parity toggles every word.
